fsgn_pipe: RTL
==============

Name: fsgn_pipe

Overview:
- Pipelined, parametrised sign-injection unit for the FPU. Executes FSGNJ, FSGNJN and FSGNJX on single- or double-precision operands.
- Single-precision operands are NaN-boxed inside the bus.
- Operands enter through a valid/ready handshake. Results leave through a valid/ready handshake with a tag and an error flag.
- Sits between the FPU issue stage and the FP writeback arbiter. Replaces the combinational sign-inject path.

Parameters:
- BUS_WIDTH, 64, operand/result width. Legal values: 32 or 64.
- STAGES, 2, pipeline depth (latency). Legal range: 1..4.
- TAG_W, 5, width of the pass-through tag (destination register index).
- NAN_PASSTHRU, 1, when 1 and in2 is NaN, the result is in1 unchanged (legacy FSGNJ behaviour). When 0, the sign of in2 is used regardless (RISC-V behaviour).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  unit accepts operands this cycle
- in1  in  BUS_WIDTH  magnitude source operand
- in2  in  BUS_WIDTH  sign source operand
- op  in  2  operation: 00 J, 01 JN, 10 JX, 11 reserved
- fmt  in  1  format: 0 single, 1 double
- in_tag  in  TAG_W  opaque tag, carried with the operation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out  out  BUS_WIDTH  result
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  illegal op/fmt combination

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - All stage valid bits = 0, so out_valid = 0.
  - out, out_tag and out_err = 0.
  - in_ready = 1 as soon as reset deasserts.
- Handshakes:
  - A transfer occurs on a rising edge with valid && ready, on both the input and output sides.
  - in_valid, in1, in2, op, fmt and in_tag must be held while in_valid && !in_ready.
  - out, out_tag and out_err are stable while out_valid && !out_ready.
- Pipeline:
  - STAGES register slots, each with its own valid bit.
  - Slot k advances when slot k+1 is empty or is itself advancing. The last slot advances on out_ready.
  - in_ready = !valid[0] || advance[0]. There is no combinational path from in_valid to in_ready.
  - in_ready may depend combinationally on out_ready.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to out_valid when there is no back-pressure.
  - Throughput is 1 result per cycle.
  - Order is preserved. No operation is dropped or duplicated under any out_ready pattern.
- Computation is done in slot 0 by fsgn_core; later slots only delay the result.
  - Double (fmt=1, BUS_WIDTH=64):
    - Result bits [62:0] = in1[62:0].
    - Result sign: J = in2[63]; JN = ~in2[63]; JX = in1[63] ^ in2[63].
  - Single (fmt=0):
    - Extract a 32-bit operand from each input.
    - When BUS_WIDTH=64, an operand whose bits [63:32] are not all ones is improperly boxed and is replaced by the canonical qNaN 32'h7FC00000.
    - Apply the same sign rule to bit 31.
    - When BUS_WIDTH=64, result bits [63:32] = all ones.
  - NaN test: exponent all ones and fraction non-zero, applied to the unboxed in2 in the selected format.
    - If NAN_PASSTHRU=1 and in2 is NaN, the result is the unboxed in1, re-boxed, with its sign unchanged.
  - Error cases: op=11, or fmt=1 with BUS_WIDTH=32, sets out_err=1 and result = in1 raw. The operation still completes normally.
- Reset mid-operation: all in-flight operations are discarded, and out_valid falls asynchronously.
- Simultaneous accept and drain when full: permitted, and sustains full throughput.

Decomposition:
- Package fsgn_pkg holds:
  - op encodings OP_J, OP_JN, OP_JX and OP_RSV
  - FMT_S and FMT_D
  - canonical NaN constants CNAN_S = 32'h7FC00000 and CNAN_D = 64'h7FF8000000000000
  - an is_nan function per format
- Sub-module fsgn_core: combinational unbox, sign inject and rebox, parametrised by BUS_WIDTH and NAN_PASSTHRU.
- fsgn_pipe holds only the handshake and the stage registers.

Test Plan:
- Double J/JN/JX, out_ready=1, STAGES=2:
  - in1=3FF0000000000000, in2=C000000000000000 -> out=BFF0000000000000 / 3FF0000000000000 / BFF0000000000000.
  - Each result appears exactly 2 cycles after acceptance, with in_tag preserved.
- NaN passthru:
  - J with in1=BFF0000000000000, in2=7FF8000000000000 -> BFF0000000000000 when NAN_PASSTHRU=1.
  - Same stimulus -> 3FF0000000000000 when NAN_PASSTHRU=0.
- Single boxing:
  - JN with in1=FFFFFFFF3F800000, in2=FFFFFFFF40000000 -> FFFFFFFFBF800000.
  - JX with in1=000000003F800000 (unboxed, becomes qNaN), in2=FFFFFFFFBF800000 -> FFFFFFFFFFC00000 (NAN_PASSTHRU=0).
- Back-pressure:
  - Issue 6 back-to-back ops with tags 0..5 while out_ready toggles 1,0,0,1,0,1...
  - Results arrive in tag order 0..5, with no loss or duplication.
  - in_ready drops only when all slots are full and out_ready=0.
- Error flag:
  - op=11 -> out_err=1, out=in1.
  - With BUS_WIDTH=32, fmt=1 -> out_err=1.
- Reset mid-flight:
  - With 2 ops in the pipe, assert rst_n low between edges -> out_valid=0 immediately.
  - After release, no stale result emerges and in_ready=1.

Source files
------------

// File: rtl/fsgn_pkg.sv
// Shared encodings, canonical NaNs and small helpers for the FP sign-injection unit.
package fsgn_pkg;

  typedef enum logic [1:0] {
    OP_J   = 2'b00,
    OP_JN  = 2'b01,
    OP_JX  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic FMT_S = 1'b0;
  localparam logic FMT_D = 1'b1;

  localparam logic [31:0] CNAN_S = 32'h7FC0_0000;
  localparam logic [63:0] CNAN_D = 64'h7FF8_0000_0000_0000;

  function automatic logic is_nan_s(input logic [31:0] v);
    return (&v[30:23]) && (|v[22:0]);
  endfunction

  function automatic logic is_nan_d(input logic [63:0] v);
    return (&v[62:52]) && (|v[51:0]);
  endfunction

  // Sign selected by the operation; the reserved code falls back to plain J.
  function automatic logic inject_sign(input logic [1:0] op, input logic s1, input logic s2);
    case (op)
      OP_JN:   return ~s2;
      OP_JX:   return s1 ^ s2;
      default: return s2;
    endcase
  endfunction

endpackage

// File: rtl/fsgn_core.sv
// Combinational unbox, sign injection and rebox for one FSGNJ/FSGNJN/FSGNJX operation.
module fsgn_core
  import fsgn_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int NAN_PASSTHRU = 1
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic [1:0]           op,
  input  logic                 fmt,
  output logic [BUS_WIDTH-1:0] res,
  output logic                 err
);

  logic [31:0]          u1;
  logic [31:0]          u2;
  logic [31:0]          res_s;
  logic                 pass_s;
  logic [BUS_WIDTH-1:0] res_ok;

  // A 64-bit bus carries singles NaN-boxed; anything not boxed reads as the canonical qNaN.
  if (BUS_WIDTH == 64) begin : g_box
    assign u1 = (&in1[63:32]) ? in1[31:0] : CNAN_S;
    assign u2 = (&in2[63:32]) ? in2[31:0] : CNAN_S;
  end else begin : g_raw
    assign u1 = in1[31:0];
    assign u2 = in2[31:0];
  end

  // NOTE: every combinational output is assigned on every path so no latch can be inferred.
  always_comb begin
    pass_s = (NAN_PASSTHRU != 0) && is_nan_s(u2);
    res_s  = pass_s ? u1 : {inject_sign(op, u1[31], u2[31]), u1[30:0]};
  end

  if (BUS_WIDTH == 64) begin : g_w64
    logic [63:0] res_d;

    always_comb begin
      res_d = ((NAN_PASSTHRU != 0) && is_nan_d(in2)) ? in1
                                                     : {inject_sign(op, in1[63], in2[63]), in1[62:0]};
    end

    assign res_ok = (fmt == FMT_D) ? res_d : {32'hFFFF_FFFF, res_s};
  end else begin : g_w32
    assign res_ok = res_s;
  end

  assign err = (op == OP_RSV) || ((fmt == FMT_D) && (BUS_WIDTH != 64));
  assign res = err ? in1 : res_ok;

endmodule

// File: rtl/fsgn_pipe.sv
// Valid/ready pipelined sign-injection unit: fsgn_core feeds slot 0, later slots only delay.
module fsgn_pipe
  import fsgn_pkg::*;
#(
  parameter int BUS_WIDTH    = 64,
  parameter int STAGES       = 2,
  parameter int TAG_W        = 5,
  parameter int NAN_PASSTHRU = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic [1:0]           op,
  input  logic                 fmt,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err
);

  logic [BUS_WIDTH-1:0] core_res;
  logic                 core_err;

  logic [STAGES-1:0]    valid_q;
  logic [STAGES-1:0]    adv;
  logic [STAGES-1:0]    load;
  logic [STAGES-1:0]    src_vld;
  logic [STAGES-1:0]    src_err;
  logic [STAGES-1:0]    err_q;
  logic [BUS_WIDTH-1:0] src_res [STAGES];
  logic [BUS_WIDTH-1:0] res_q   [STAGES];
  logic [TAG_W-1:0]     src_tag [STAGES];
  logic [TAG_W-1:0]     tag_q   [STAGES];

  fsgn_core #(
    .BUS_WIDTH   (BUS_WIDTH),
    .NAN_PASSTHRU(NAN_PASSTHRU)
  ) u_core (
    .in1(in1),
    .in2(in2),
    .op (op),
    .fmt(fmt),
    .res(core_res),
    .err(core_err)
  );

  // A slot advances if its successor is empty or advancing; a slot loads if empty or advancing.
  always_comb begin
    adv            = '0;
    adv[STAGES-1]  = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k+1] || adv[k+1];
    end
    load = ~valid_q | adv;
  end

  always_comb begin
    src_vld[0] = in_valid;
    src_res[0] = core_res;
    src_tag[0] = in_tag;
    src_err[0] = core_err;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = valid_q[k-1];
      src_res[k] = res_q[k-1];
      src_tag[k] = tag_q[k-1];
      src_err[k] = err_q[k-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every slot sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) valid_q[k] <= src_vld[k];
      end
    end
  end

  // NOTE: the data slots are reset too, because out, out_tag and out_err must read zero from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
        err_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k] && src_vld[k]) begin
          res_q[k] <= src_res[k];
          tag_q[k] <= src_tag[k];
          err_q[k] <= src_err[k];
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule
